input_debounce: RTL

Input conditioning stage between the board header pins (J1) and the 4-input NOR array on the iCE40 target. It synchronises each asynchronous pin into the CLK domain and debounces it with a per-bit stability counter. It presents clean levels on `O`, which connect directly to the `I0..I3` bit-slices of the NOR stage. Optional per-bit rise/fall strobes support downstream event logic.

---
 rtl/input_debounce.sv | 106 ++++++++++
 1 files changed

// File: rtl/input_debounce.sv
// input_debounce
//
// Conditions the raw J1 header pins for the 4-input NOR array. Each pin is
// brought into the CLK domain through a synchroniser chain, then
// debounced with its own stability counter. O moves only after the
// synchronised level has differed from O for DEBOUNCE_CYCLES consecutive
// cycles.
//
// Optional feature macro: INPUT_DEBOUNCE_EDGE_EN
//   defined   - RISE/FALL are registered one-cycle strobes that are high in
//               the cycle O[i] first shows its new value.
//   undefined - RISE/FALL stay on the port list tied to 0; no strobe flops.
//
// Parameters
//   WIDTH           number of independent input bits
//   SYNC_STAGES     synchroniser flops per bit (2 or more)
//   DEBOUNCE_CYCLES stable cycles required before O follows (1 or more)
//
// Ports
//   CLK    single clock, rising edge
//   RESET  synchronous, active-high
//   I      raw asynchronous pin levels
//   O      debounced levels, registered
//   RISE   one-cycle strobe on O[i] 0->1
//   FALL   one-cycle strobe on O[i] 1->0

module input_debounce #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] O,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL
);

    // A width of 1 keeps the counter legal when DEBOUNCE_CYCLES is 1; in
    // that case the compare value is 0 and every difference expires at once.
    localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] differ;
    logic [WIDTH-1:0] expire;

    assign s      = sync_q[SYNC_STAGES-1];
    assign differ = s ^ O;

    always_comb begin
        expire = '0;
        for (int i = 0; i < WIDTH; i++) begin
            expire[i] = differ[i] && (cnt_q[i] == CNT_MAX);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            O <= '0;
        end else begin
            sync_q[0] <= I;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            // A return to O before expiry clears the count, so only an
            // unbroken run of DEBOUNCE_CYCLES differing samples gets through.
            // Expiry also clears it, which bounds the counter at CNT_MAX.
            for (int i = 0; i < WIDTH; i++) begin
                if (!differ[i] || expire[i]) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
            O <= O ^ expire;
        end
    end

`ifdef INPUT_DEBOUNCE_EDGE_EN
    // Registered in the same edge as O, so each strobe lines up with the
    // first cycle O shows the new value. s is the new value on expiry.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            RISE <= '0;
            FALL <= '0;
        end else begin
            RISE <= expire & s;
            FALL <= expire & ~s;
        end
    end
`else
    assign RISE = '0;
    assign FALL = '0;
`endif

endmodule
